// File: rtl/beep_pkg.sv
// Shared types and helpers for the beep player: FSM state encoding,
// note-entry field extraction and beat divider computation.
package beep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_PLAY  = 2'd2,
        ST_PAUSE = 2'd3
    } state_t;

    // Clocks per beat; never below 1 so the beat counter always wraps.
    function automatic int calc_beat_div(input int clk_hz, input int beat_hz);
        int div;
        div = clk_hz / beat_hz;
        return (div < 1) ? 1 : div;
    endfunction

    // Entries are packed {dur, half_period}; callers pass their field widths.
    function automatic logic [31:0] entry_hp(input logic [63:0] entry, input int hp_w);
        return 32'(entry & ((64'd1 << hp_w) - 64'd1));
    endfunction

    function automatic logic [31:0] entry_dur(input logic [63:0] entry, input int hp_w,
                                              input int dur_w);
        return 32'((entry >> hp_w) & ((64'd1 << dur_w) - 64'd1));
    endfunction

endpackage

// File: rtl/beep_tone.sv
// Square-wave tone divider. The phase survives while en is low (pause), but the
// registered wave output is forced low whenever the divider is not advancing.
module beep_tone #(
    parameter int HP_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [HP_W-1:0] half_period,
    output logic            wave
);

    logic [HP_W-1:0] cnt_reg;
    logic            phase_reg;
    logic            wave_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
            wave_reg  <= 1'b0;
        end else if (en) begin
            if (half_period == '0) begin
                cnt_reg   <= '0;
                phase_reg <= 1'b0;
                wave_reg  <= 1'b0;
            end else if (cnt_reg == half_period - HP_W'(1)) begin
                cnt_reg   <= '0;
                phase_reg <= ~phase_reg;
                wave_reg  <= ~phase_reg;
            end else begin
                cnt_reg  <= cnt_reg + HP_W'(1);
                wave_reg <= phase_reg;
            end
        end else begin
            wave_reg <= 1'b0;
        end
    end

    assign wave = wave_reg;

endmodule

// File: rtl/beep_player.sv
// Note-sequencer buzzer: plays {dur, half_period} entries from an on-chip
// note memory, with pause, stop and loop control.
module beep_player
    import beep_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BEAT_HZ = 5,
    parameter int HP_W    = 16,
    parameter int DUR_W   = 4,
    parameter int ADDR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DUR_W+HP_W-1:0] wr_data,
    input  logic [ADDR_W:0]       song_len,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  loop_en,
    output logic                  beep_out,
    output logic                  playing,
    output logic [ADDR_W-1:0]     note_idx,
    output logic                  done
);

    localparam int BEAT_DIV = calc_beat_div(CLK_HZ, BEAT_HZ);
    localparam int BC_W     = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam int ENTRY_W  = DUR_W + HP_W;
    localparam int DEPTH    = 2 ** ADDR_W;
    localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BEAT_DIV - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   note_idx_reg, note_idx_next;
    logic [BC_W-1:0]     beat_cnt_reg, beat_cnt_next;
    logic [DUR_W-1:0]    beats_left_reg, beats_left_next;
    logic [HP_W-1:0]     hp_reg, hp_next;
    logic                done_reg, done_next;
    logic                playing_reg;
    logic                tone_clr, tone_en;

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [ENTRY_W-1:0]  rd_data_reg;
    logic [HP_W-1:0]     load_hp;
    logic [DUR_W-1:0]    load_dur;
    logic [ADDR_W:0]     idx_plus1;

    // Read address follows the index the FSM is about to hold, so the entry
    // is already registered by the time LOAD samples it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_reg <= mem[note_idx_next];
    end

    assign load_hp   = HP_W'(entry_hp(64'(rd_data_reg), HP_W));
    assign load_dur  = DUR_W'(entry_dur(64'(rd_data_reg), HP_W, DUR_W));
    assign idx_plus1 = {1'b0, note_idx_reg} + (ADDR_W+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            note_idx_reg   <= '0;
            beat_cnt_reg   <= '0;
            beats_left_reg <= '0;
            hp_reg         <= '0;
            done_reg       <= 1'b0;
            playing_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            note_idx_reg   <= note_idx_next;
            beat_cnt_reg   <= beat_cnt_next;
            beats_left_reg <= beats_left_next;
            hp_reg         <= hp_next;
            done_reg       <= done_next;
            playing_reg    <= (state_next != ST_IDLE);
        end
    end

    always_comb begin
        state_next      = state_reg;
        note_idx_next   = note_idx_reg;
        beat_cnt_next   = beat_cnt_reg;
        beats_left_next = beats_left_reg;
        hp_next         = hp_reg;
        done_next       = 1'b0;
        tone_en         = 1'b0;
        tone_clr        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start && !stop && (song_len != '0)) begin
                    note_idx_next = '0;
                    state_next    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                tone_clr = 1'b1;
                if (stop) begin
                    state_next = ST_IDLE;
                end else begin
                    hp_next         = load_hp;
                    beats_left_next = (load_dur == '0) ? DUR_W'(1) : load_dur;
                    beat_cnt_next   = '0;
                    state_next      = ST_PLAY;
                end
            end
            ST_PLAY, ST_PAUSE: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (pause) begin
                    state_next = ST_PAUSE;
                end else begin
                    // A released pause resumes counting in the same cycle, so a
                    // pause held N clocks stretches the note by exactly N clocks.
                    state_next = ST_PLAY;
                    tone_en    = 1'b1;
                    if (beat_cnt_reg == BEAT_LAST) begin
                        beat_cnt_next = '0;
                        if (beats_left_reg <= DUR_W'(1)) begin
                            beats_left_next = '0;
                            if (idx_plus1 < song_len) begin
                                note_idx_next = note_idx_reg + ADDR_W'(1);
                                state_next    = ST_LOAD;
                            end else if (loop_en && (song_len != '0)) begin
                                note_idx_next = '0;
                                state_next    = ST_LOAD;
                            end else begin
                                done_next  = 1'b1;
                                state_next = ST_IDLE;
                            end
                        end else begin
                            beats_left_next = beats_left_reg - DUR_W'(1);
                        end
                    end else begin
                        beat_cnt_next = beat_cnt_reg + BC_W'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if ((state_next == ST_IDLE) || (state_next == ST_LOAD)) begin
            tone_clr = 1'b1;
        end
    end

    beep_tone #(
        .HP_W(HP_W)
    ) u_tone (
        .clk        (clk),
        .rst        (rst),
        .clr        (tone_clr),
        .en         (tone_en),
        .half_period(hp_reg),
        .wave       (beep_out)
    );

    assign playing  = playing_reg;
    assign note_idx = note_idx_reg;
    assign done     = done_reg;

endmodule

// File: tb/tb_beep_player.sv
// Directed bench for beep_player at CLK_HZ=100, BEAT_HZ=10 (10 clocks per beat).
module tb_beep_player;

    localparam int HP_W   = 16;
    localparam int DUR_W  = 4;
    localparam int ADDR_W = 8;
    localparam int LOGN   = 128;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  wr_en = 1'b0;
    logic [ADDR_W-1:0]     wr_addr = '0;
    logic [DUR_W+HP_W-1:0] wr_data = '0;
    logic [ADDR_W:0]       song_len = '0;
    logic                  start = 1'b0;
    logic                  stop = 1'b0;
    logic                  pause = 1'b0;
    logic                  loop_en = 1'b0;
    logic                  beep_out;
    logic                  playing;
    logic [ADDR_W-1:0]     note_idx;
    logic                  done;

    beep_player #(
        .CLK_HZ (100),
        .BEAT_HZ(10),
        .HP_W   (HP_W),
        .DUR_W  (DUR_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .song_len(song_len),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .loop_en (loop_en),
        .beep_out(beep_out),
        .playing (playing),
        .note_idx(note_idx),
        .done    (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic              wave_log [LOGN];
    logic              play_log [LOGN];
    logic              done_log [LOGN];
    logic [ADDR_W-1:0] idx_log  [LOGN];

    typedef struct {
        logic [DUR_W-1:0] dur;
        logic [HP_W-1:0]  hp;
        int               exp_len;
        int               exp_high;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic wr(input int addr, input int dur, input int hp);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = {DUR_W'(dur), HP_W'(hp)};
        tick();
        wr_en   = 1'b0;
    endtask

    // Pulse start, then log n cycles; index 0 is the LOAD cycle of the first entry.
    task automatic run(input int n, input int pause_at, input int pause_len,
                       input int stop_at, input int rst_at);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            wave_log[i] = beep_out;
            play_log[i] = playing;
            done_log[i] = done;
            idx_log[i]  = note_idx;
            pause = (pause_at >= 0) && (i >= pause_at) && (i < pause_at + pause_len);
            stop  = (i == stop_at);
            rst   = (i == rst_at);
            tick();
        end
        pause = 1'b0;
        stop  = 1'b0;
        rst   = 1'b0;
    endtask

    function automatic int first_done(input int n);
        for (int i = 0; i < n; i++) if (done_log[i]) return i;
        return -1;
    endfunction

    function automatic int count_done(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (done_log[i]) c++;
        return c;
    endfunction

    function automatic int count_high(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (wave_log[i]) c++;
        return c;
    endfunction

    function automatic int count_play(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (play_log[i]) c++;
        return c;
    endfunction

    initial begin
        logic [27:0] exp_mask;
        logic [27:0] got_mask;
        int          guard_done;
        int          guard_play;

        vecs[0] = '{dur: 4'd2, hp: 16'd3, exp_len: 21, exp_high: 9};
        vecs[1] = '{dur: 4'd1, hp: 16'd2, exp_len: 11, exp_high: 4};
        vecs[2] = '{dur: 4'd1, hp: 16'd5, exp_len: 11, exp_high: 5};
        vecs[3] = '{dur: 4'd0, hp: 16'd1, exp_len: 11, exp_high: 5};
        vecs[4] = '{dur: 4'd3, hp: 16'd0, exp_len: 31, exp_high: 0};
        vecs[5] = '{dur: 4'd1, hp: 16'd4, exp_len: 11, exp_high: 4};

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset beep_out", int'(beep_out), 0);
        chk("reset playing", int'(playing), 0);
        chk("reset note_idx", int'(note_idx), 0);
        chk("reset done", int'(done), 0);

        // Single-note table: note length, high-cycle count, single done pulse.
        song_len = 9'd1;
        loop_en  = 1'b0;
        foreach (vecs[v]) begin
            wr(0, int'(vecs[v].dur), int'(vecs[v].hp));
            run(vecs[v].exp_len + 3, -1, 0, -1, -1);
            chk($sformatf("vec%0d done_at", v), first_done(vecs[v].exp_len + 3), vecs[v].exp_len);
            chk($sformatf("vec%0d done_cnt", v), count_done(vecs[v].exp_len + 3), 1);
            chk($sformatf("vec%0d play_cycles", v), count_play(vecs[v].exp_len + 3), vecs[v].exp_len);
            chk($sformatf("vec%0d high_cycles", v), count_high(0, vecs[v].exp_len - 1), vecs[v].exp_high);
        end

        // {dur=2,H=3}: period-6 square wave, high at PLAY cycles 4-6, 10-12, 16-18.
        wr(0, 2, 3);
        run(24, -1, 0, -1, -1);
        exp_mask = 28'h0071C70;
        got_mask = '0;
        for (int i = 0; i < 21; i++) got_mask[i] = wave_log[i];
        chk("h3 wave pattern", int'(got_mask), int'(exp_mask));
        chk("h3 done_at", first_done(24), 21);
        chk("h3 idle after", int'(play_log[22]), 0);

        // Pause for 7 clocks from cycle 8: note ends 7 later, wave pattern shifted by 7.
        run(31, 8, 7, -1, -1);
        exp_mask = 28'h38E0070;
        got_mask = '0;
        for (int i = 0; i < 28; i++) got_mask[i] = wave_log[i];
        chk("pause wave pattern", int'(got_mask), int'(exp_mask));
        chk("pause done_at", first_done(31), 28);
        chk("pause playing held", int'(play_log[12]), 1);
        chk("pause done_cnt", count_done(31), 1);

        // start+stop+pause together mid-note: stop wins.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start = 1'b1;
        stop  = 1'b1;
        pause = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        chk("coincide playing", int'(playing), 0);
        chk("coincide beep_out", int'(beep_out), 0);
        guard_done = 0;
        guard_play = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) guard_done++;
            if (playing) guard_play++;
            tick();
        end
        chk("coincide no done", guard_done, 0);
        chk("coincide stays idle", guard_play, 0);

        // song_len == 0: start is ignored.
        song_len = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("len0 playing", int'(playing), 0);
        tick();
        chk("len0 playing later", int'(playing), 0);

        // Three-entry song, no loop.
        wr(0, 1, 2);
        wr(1, 1, 0);
        wr(2, 1, 5);
        song_len = 9'd3;
        run(36, -1, 0, -1, -1);
        chk("song idx0", int'(idx_log[5]), 0);
        chk("song idx1", int'(idx_log[15]), 1);
        chk("song idx2", int'(idx_log[27]), 2);
        chk("song rest silent", count_high(11, 21), 0);
        chk("song entry0 highs", count_high(0, 10), 4);
        chk("song entry2 highs", count_high(22, 32), 5);
        chk("song done_at", first_done(36), 33);
        chk("song done_cnt", count_done(36), 1);

        // Same song looping, then stop while beep_out is high.
        loop_en = 1'b1;
        run(40, -1, 0, 36, -1);
        chk("loop idx before wrap", int'(idx_log[32]), 2);
        chk("loop idx after wrap", int'(idx_log[33]), 0);
        chk("loop no done", count_done(40), 0);
        chk("loop beep before stop", int'(wave_log[36]), 1);
        chk("loop playing before stop", int'(play_log[36]), 1);
        chk("stop playing", int'(play_log[37]), 0);
        chk("stop beep_out", int'(wave_log[37]), 0);
        loop_en = 1'b0;

        // Reset mid-note, then replay from retained memory.
        run(32, -1, 0, -1, 29);
        chk("rst pre beep", int'(wave_log[29]), 1);
        chk("rst pre idx", int'(idx_log[29]), 2);
        chk("rst beep_out", int'(wave_log[30]), 0);
        chk("rst playing", int'(play_log[30]), 0);
        chk("rst note_idx", int'(idx_log[30]), 0);
        chk("rst done", int'(done_log[30]), 0);
        run(36, -1, 0, -1, -1);
        chk("replay done_at", first_done(36), 33);
        chk("replay highs", count_high(0, 32), 9);
        chk("replay idx1", int'(idx_log[15]), 1);
        chk("replay idx2", int'(idx_log[27]), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
